// File: rtl/compositor_pkg.sv
// Shared constants for the sprite compositor: default playfield geometry,
// transparent key and the per-sprite wall_col bit layout.
package compositor_pkg;

  localparam int          DEF_SPRITE_SIZE = 16;
  localparam int          DEF_BG_W        = 1000;
  localparam int          DEF_BG_H        = 1000;
  localparam logic [23:0] DEF_TRANS_KEY   = 24'h171717;

  localparam int WALL_RIGHT  = 0;
  localparam int WALL_LEFT   = 1;
  localparam int WALL_BOTTOM = 2;
  localparam int WALL_TOP    = 3;
  localparam int WALL_BITS   = 4;

endpackage

// File: rtl/sprite_priority_enc.sv
// Lowest-index-first priority encoder over the opaque mask, with any/multi
// hit flags. idx is only meaningful when any_hit is set.
module sprite_priority_enc #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N) + 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any_hit,
  output logic             multi_hit
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign any_hit = |mask;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit = (mask & (mask - N'(1))) != '0;

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite compositor: transparency keying, fixed-priority select through a
// 2-stage pipeline, playfield wall flags and per-frame overlap reporting.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int COLOR_W = 8,
  parameter int POS_W = 10,
  parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
  parameter int BG_W = DEF_BG_W,
  parameter int BG_H = DEF_BG_H,
  parameter logic [3*COLOR_W-1:0] TRANS_KEY = DEF_TRANS_KEY,
  localparam int PIX_W = 3 * COLOR_W,
  localparam int SEL_W = $clog2(N_SPRITES) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_valid_in,
  input  logic                           frame_start,
  input  logic [PIX_W-1:0]               bg_rgb,
  input  logic [N_SPRITES*PIX_W-1:0]     sp_rgb,
  input  logic [N_SPRITES-1:0]           sp_en,
  input  logic [N_SPRITES*POS_W-1:0]     sp_x,
  input  logic [N_SPRITES*POS_W-1:0]     sp_y,
  output logic                           pix_valid_out,
  output logic [PIX_W-1:0]               rgb_out,
  output logic [SEL_W-1:0]               sp_sel,
  output logic [WALL_BITS*N_SPRITES-1:0] wall_col,
  output logic [N_SPRITES-1:0]           sp_col,
  output logic                           sp_col_valid
);

  logic [N_SPRITES-1:0]           opaque;
  logic [WALL_BITS*N_SPRITES-1:0] wall_next;
  logic [SEL_W-1:0]               enc_idx;
  logic                           any_hit;
  logic                           multi_hit;
  logic [SEL_W-1:0]               win_idx;
  logic [N_SPRITES-1:0]           col_contrib;
  logic [N_SPRITES-1:0]           col_acc;

  logic                           valid_q;
  logic [N_SPRITES-1:0]           opaque_q;
  logic [SEL_W-1:0]               sel_q;
  logic [PIX_W-1:0]               bg_q;
  logic [N_SPRITES*PIX_W-1:0]     sp_q;
  logic [PIX_W-1:0]               mux_rgb;

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_sprite
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    assign x = sp_x[g*POS_W +: POS_W];
    assign y = sp_y[g*POS_W +: POS_W];

    assign opaque[g] = sp_en[g] && (sp_rgb[g*PIX_W +: PIX_W] != TRANS_KEY);

    // One extra bit on the sums so a sprite near the coordinate limit cannot wrap.
    assign wall_next[WALL_BITS*g + WALL_RIGHT]  =
      ({1'b0, x} + (POS_W+1)'(SPRITE_SIZE)) >= (POS_W+1)'(BG_W);
    assign wall_next[WALL_BITS*g + WALL_LEFT]   = (x == '0);
    assign wall_next[WALL_BITS*g + WALL_BOTTOM] =
      ({1'b0, y} + (POS_W+1)'(SPRITE_SIZE)) >= (POS_W+1)'(BG_H);
    assign wall_next[WALL_BITS*g + WALL_TOP]    = (y == '0);
  end

  sprite_priority_enc #(.N(N_SPRITES)) u_enc (
    .mask      (opaque),
    .idx       (enc_idx),
    .any_hit   (any_hit),
    .multi_hit (multi_hit)
  );

  assign win_idx     = any_hit ? enc_idx : SEL_W'(N_SPRITES);
  assign col_contrib = (pix_valid_in && multi_hit) ? opaque : '0;

  // Stage 1: capture the decision and all candidate pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      opaque_q <= '0;
      sel_q    <= '0;
      bg_q     <= '0;
      sp_q     <= '0;
    end else begin
      valid_q <= pix_valid_in;
      if (pix_valid_in) begin
        opaque_q <= opaque;
        sel_q    <= win_idx;
        bg_q     <= bg_rgb;
        sp_q     <= sp_rgb;
      end
    end
  end

  always_comb begin
    mux_rgb = bg_q;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (opaque_q[i] && sel_q == SEL_W'(i)) mux_rgb = sp_q[i*PIX_W +: PIX_W];
    end
  end

  // Stage 2: outputs hold their last value between valid pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_out <= 1'b0;
      rgb_out       <= '0;
      sp_sel        <= '0;
    end else begin
      pix_valid_out <= valid_q;
      if (valid_q) begin
        rgb_out <= mux_rgb;
        sp_sel  <= sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wall_col <= '0;
    else       wall_col <= wall_next;
  end

  // A pixel arriving with frame_start seeds the new frame's accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_acc      <= '0;
      sp_col       <= '0;
      sp_col_valid <= 1'b0;
    end else if (frame_start) begin
      sp_col       <= col_acc;
      sp_col_valid <= 1'b1;
      col_acc      <= col_contrib;
    end else begin
      sp_col_valid <= 1'b0;
      col_acc      <= col_acc | col_contrib;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_sprite_compositor;

  localparam int N     = 4;
  localparam int PW    = 10;
  localparam int PIX_W = 24;
  localparam int SEL_W = 3;
  localparam logic [23:0] KEY = 24'h171717;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               pix_valid_in = 1'b0;
  logic               frame_start = 1'b0;
  logic [PIX_W-1:0]   bg_rgb = '0;
  logic [N*PIX_W-1:0] sp_rgb = '0;
  logic [N-1:0]       sp_en = '0;
  logic [N*PW-1:0]    sp_x = '0;
  logic [N*PW-1:0]    sp_y = '0;
  logic               pix_valid_out;
  logic [PIX_W-1:0]   rgb_out;
  logic [SEL_W-1:0]   sp_sel;
  logic [4*N-1:0]     wall_col;
  logic [N-1:0]       sp_col;
  logic               sp_col_valid;

  sprite_compositor dut (
    .clk           (clk),
    .reset         (reset),
    .pix_valid_in  (pix_valid_in),
    .frame_start   (frame_start),
    .bg_rgb        (bg_rgb),
    .sp_rgb        (sp_rgb),
    .sp_en         (sp_en),
    .sp_x          (sp_x),
    .sp_y          (sp_y),
    .pix_valid_out (pix_valid_out),
    .rgb_out       (rgb_out),
    .sp_sel        (sp_sel),
    .wall_col      (wall_col),
    .sp_col        (sp_col),
    .sp_col_valid  (sp_col_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pixels queue up and emerge one clock edge after capture.
  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  sel;
  } pix_t;

  pix_t        pq[$];
  pix_t        p;
  bit          prev_valid;
  bit          e_vout;
  logic [23:0] e_rgb;
  logic [2:0]  e_sel;
  logic [15:0] e_wall;
  logic [3:0]  e_col;
  logic [3:0]  acc;
  bit          e_colv;
  logic [3:0]  op;
  logic [3:0]  contrib;
  int          cnt;
  int          win;
  int          xv;
  int          yv;

  always begin
    @(posedge clk);
    if (reset) begin
      pq.delete();
      prev_valid = 0; e_vout = 0; e_rgb = '0; e_sel = '0;
      e_wall = '0; e_col = '0; acc = '0; e_colv = 0;
    end else begin
      op = '0; cnt = 0; win = N;
      for (int i = N - 1; i >= 0; i--) begin
        if (sp_en[i] && sp_rgb[i*PIX_W +: PIX_W] != KEY) begin
          op[i] = 1'b1; cnt++; win = i;
        end
      end
      e_vout = prev_valid;
      prev_valid = pix_valid_in;
      if (e_vout) begin
        if (pq.size() == 0) chk("model_queue_empty", 64'd0, 64'd1);
        else begin
          p = pq.pop_front();
          e_rgb = p.rgb; e_sel = p.sel;
        end
      end
      if (pix_valid_in) begin
        p.sel = 3'(win);
        if (win == N) p.rgb = bg_rgb;
        else          p.rgb = sp_rgb[win*PIX_W +: PIX_W];
        pq.push_back(p);
      end
      for (int i = 0; i < N; i++) begin
        xv = int'(sp_x[i*PW +: PW]);
        yv = int'(sp_y[i*PW +: PW]);
        e_wall[4*i+0] = (xv + 16 >= 1000);
        e_wall[4*i+1] = (xv == 0);
        e_wall[4*i+2] = (yv + 16 >= 1000);
        e_wall[4*i+3] = (yv == 0);
      end
      contrib = (pix_valid_in && cnt >= 2) ? op : 4'b0;
      if (frame_start) begin
        e_col = acc; e_colv = 1; acc = contrib;
      end else begin
        e_colv = 0; acc = acc | contrib;
      end
    end
    #1;
    chk("pix_valid_out", 64'(pix_valid_out), 64'(e_vout));
    if (e_vout) begin
      chk("rgb_out", 64'(rgb_out), 64'(e_rgb));
      chk("sp_sel", 64'(sp_sel), 64'(e_sel));
    end
    chk("wall_col", 64'(wall_col), 64'(e_wall));
    chk("sp_col", 64'(sp_col), 64'(e_col));
    chk("sp_col_valid", 64'(sp_col_valid), 64'(e_colv));
  end

  task automatic set_sp(input int i, input logic [23:0] c);
    sp_rgb[i*PIX_W +: PIX_W] = c;
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    sp_x[i*PW +: PW] = PW'(x);
    sp_y[i*PW +: PW] = PW'(y);
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid_out"}, 64'(pix_valid_out), 64'd0);
    chk({tag, "_rgb_out"}, 64'(rgb_out), 64'd0);
    chk({tag, "_sp_sel"}, 64'(sp_sel), 64'd0);
    chk({tag, "_wall_col"}, 64'(wall_col), 64'd0);
    chk({tag, "_sp_col"}, 64'(sp_col), 64'd0);
    chk({tag, "_sp_col_valid"}, 64'(sp_col_valid), 64'd0);
  endtask

  int pick;

  initial begin
    for (int i = 0; i < N; i++) set_pos(i, 500, 500);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    after_edge();
    chk_all_zero("reset");

    // Transparency and priority
    @(negedge clk);
    set_sp(0, KEY); set_sp(1, 24'hFF0000); set_sp(2, 24'h00FF00); set_sp(3, 24'h123456);
    bg_rgb = 24'h0000FF; sp_en = 4'b1111; pix_valid_in = 1'b1;
    @(negedge clk); pix_valid_in = 1'b0;
    after_edge();
    chk("prio_rgb", 64'(rgb_out), 64'hFF0000);
    chk("prio_sel", 64'(sp_sel), 64'd1);

    // All disabled, then all transparent
    @(negedge clk); sp_en = 4'b0000; pix_valid_in = 1'b1;
    @(negedge clk); pix_valid_in = 1'b0;
    after_edge();
    chk("dis_rgb", 64'(rgb_out), 64'h0000FF);
    chk("dis_sel", 64'(sp_sel), 64'd4);
    @(negedge clk);
    for (int i = 0; i < N; i++) set_sp(i, KEY);
    sp_en = 4'b1111; bg_rgb = 24'hABCDEF; pix_valid_in = 1'b1;
    @(negedge clk); pix_valid_in = 1'b0;
    after_edge();
    chk("trans_rgb", 64'(rgb_out), 64'hABCDEF);
    chk("trans_sel", 64'(sp_sel), 64'd4);

    // Throughput: 4 pixels, gap, 4 pixels
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      pix_valid_in = (k != 4);
      bg_rgb = 24'($urandom);
      for (int i = 0; i < N; i++) set_sp(i, ($urandom_range(0, 2) == 0) ? KEY : 24'($urandom));
    end
    @(negedge clk); pix_valid_in = 1'b0;

    // Overlap: frame A with sp1 and sp3 overlapping, then empty frame B
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    set_sp(0, KEY); set_sp(1, 24'h112233); set_sp(2, KEY); set_sp(3, 24'h445566);
    pix_valid_in = 1'b1;
    @(negedge clk); pix_valid_in = 1'b0; frame_start = 1'b1;
    after_edge();
    chk("ovl_col_a", 64'(sp_col), 64'b1010);
    chk("ovl_valid_a", 64'(sp_col_valid), 64'd1);
    @(negedge clk); frame_start = 1'b0;
    after_edge();
    chk("ovl_valid_drop", 64'(sp_col_valid), 64'd0);
    chk("ovl_col_hold", 64'(sp_col), 64'b1010);
    @(negedge clk); frame_start = 1'b1;
    after_edge();
    chk("ovl_col_b", 64'(sp_col), 64'd0);
    @(negedge clk); frame_start = 1'b0;

    // Boundary flags
    set_pos(0, 0, 0); set_pos(1, 984, 500); set_pos(2, 500, 984);
    after_edge();
    chk("wall_sp0_corner", 64'(wall_col[3:0]), 64'b1010);
    chk("wall_sp1_right", 64'(wall_col[7:4]), 64'b0001);
    chk("wall_sp2_bottom", 64'(wall_col[11:8]), 64'b0100);
    @(negedge clk); set_pos(1, 983, 500);
    after_edge();
    chk("wall_sp1_clear", 64'(wall_col[7:4]), 64'd0);
    @(negedge clk);
    for (int i = 0; i < N; i++) set_pos(i, 500, 500);

    // Reset mid-frame with overlapping pixels in flight
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0; pix_valid_in = 1'b1;
    @(negedge clk); reset = 1'b1;
    after_edge();
    chk_all_zero("rst_cyc");
    @(negedge clk); reset = 1'b0; pix_valid_in = 1'b0;
    after_edge();
    chk_all_zero("rst_after");
    @(negedge clk); frame_start = 1'b1;
    after_edge();
    chk("rst_col", 64'(sp_col), 64'd0);
    chk("rst_col_valid", 64'(sp_col_valid), 64'd1);
    @(negedge clk); frame_start = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      reset        = ($urandom_range(0, 400) == 0);
      pix_valid_in = ($urandom_range(0, 3) != 0);
      frame_start  = ($urandom_range(0, 40) == 0);
      sp_en        = 4'($urandom);
      bg_rgb       = 24'($urandom);
      for (int i = 0; i < N; i++) begin
        set_sp(i, ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom));
        if ($urandom_range(0, 7) == 0) begin
          pick = int'($urandom_range(0, 4));
          case (pick)
            0: set_pos(i, 0, int'($urandom_range(0, 1023)));
            1: set_pos(i, 983 + int'($urandom_range(0, 2)), 0);
            2: set_pos(i, int'($urandom_range(0, 1023)), 983 + int'($urandom_range(0, 2)));
            default: set_pos(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
          endcase
        end
      end
    end
    @(negedge clk);
    reset = 1'b0; pix_valid_in = 1'b0; frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
